matmul_seq: RTL and testbench
=============================

Name: matmul_seq

Overview:
- Parametrised sequential successor to the combinational 2x2 matrix multiplier: computes C = A x B, or C = C + A x B, for NxN unsigned matrices.
- Uses a single shared multiply-accumulate (MAC) unit driven by an i/j/k loop FSM.
- Valid/ready handshake on the input and output sides, so it slots into streaming datapaths in place of the flat combinational block.

Parameters:
- N, 2, matrix dimension (N >= 2).
- DW, 4, element width of A and B, unsigned.
- OW, 2*DW+$clog2(N), element width of C. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block is idle and can accept operands.
- acc_mode  in  1  0: C = AxB; 1: C = C_prev + AxB. Sampled at acceptance.
- a_flat  in  N*N*DW  matrix A; element (r,c) at [(r*N+c)*DW +: DW].
- b_flat  in  N*N*DW  matrix B; same packing as A.
- c_flat  out  N*N*OW  result matrix C; element (r,c) at [(r*N+c)*OW +: OW]; registered.
- out_valid  out  1  c_flat holds a completed result.
- out_ready  in  1  downstream consumes the result.

Behaviour:
- Reset:
  - State goes to IDLE.
  - c_flat = 0, out_valid = 0, accumulator = 0, i = j = k = 0.
  - in_valid is ignored while rst = 1.
  - rst overrides everything, including mid-CALC and mid-DONE; the partial result is discarded.
- in_ready = (state == IDLE), combinational from state. out_valid = (state == DONE), registered.
- IDLE:
  - On an edge with in_valid & in_ready: capture a_flat, b_flat and acc_mode into internal registers; clear the accumulator and i/j/k; go to CALC.
  - Later changes on a_flat/b_flat do not affect the result.
- CALC (one MAC per cycle):
  - sum = acc + A[i][k]*B[k][j]. The product is 2*DW bits, zero-extended to OW.
  - If k < N-1: acc <= sum; k++.
  - If k == N-1: write C[i][j] <= sum + (acc_mode ? C_prev[i][j] : 0), modulo 2^OW. Then acc <= 0, k <= 0, advance j, and on j wrap advance i.
  - After element (N-1,N-1) is written, go to DONE.
- Latency: out_valid rises exactly N^3 cycles after the accepting edge (8 cycles for N = 2). Throughput is one matrix per N^3+2 cycles with out_ready held high.
- C_prev is the c_flat contents at acceptance time. Elements are overwritten in row-major order during CALC, and each element reads its own old value before it is overwritten.
- Arithmetic width:
  - Non-accumulate results never overflow; OW bounds N*(2^DW-1)^2.
  - Accumulate mode wraps modulo 2^OW. There is no saturation and no overflow flag.
- DONE:
  - Hold c_flat stable and out_valid = 1 until out_ready = 1, then go to IDLE on that edge.
  - in_valid is ignored in CALC and DONE because in_ready = 0.
  - The earliest new acceptance is the cycle after the out_ready handshake.
- out_ready asserted outside DONE has no effect.
- c_flat changes only in CALC and on reset. In IDLE it retains the last result, which serves as C_prev for the next accumulate.

Decomposition:
- Package matmul_pkg holds:
  - State enum {IDLE, CALC, DONE}.
  - A function computing OW from DW and N.
  - Index helper functions for the flat-bus slice offsets.
- Sub-module mac_unit (DW, OW): combinational sum = acc + a*b.
- The FSM, counters and C register file live in matmul_seq.

Test Plan:
- N=2, DW=4, A={1,2,3,4}, B={5,6,7,8}, acc_mode=0 -> c_flat={19,22,43,50}, out_valid high 8 cycles after acceptance, in_ready low for those 8 cycles.
- All elements 15, acc_mode=0 -> every C = 450 (OW=9), no wrap. Repeat with acc_mode=1 -> every C = 900 mod 512 = 388.
- Identity A={1,0,0,1} with B={5,6,7,8}, acc_mode=0, then again with acc_mode=1 -> first {5,6,7,8}, then {10,12,14,16}.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a_flat -> c_flat and out_valid stable, nothing accepted. Release out_ready -> in_ready=1 on the next cycle.
- Assert rst for 1 cycle at the 4th CALC cycle -> next cycle: out_valid=0, c_flat=0, in_ready=1. A fresh {1,2,3,4}x{5,6,7,8} then yields {19,22,43,50}.
- N=3, DW=8, random matrices over 100 iterations with random out_ready stalls -> c_flat matches the reference model, and out_valid rises 27 cycles after each acceptance.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Holds the FSM state encoding and flat-bus index arithmetic.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int ow_calc(int dw, int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Bit offset of element (r,c) in a row-major flat bus of width w.
    function automatic int elem_off(int r, int c, int n, int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/matmul_if.sv
// Operand/result stream bundle for matmul_seq.
// Input and output sides each carry a valid/ready pair.
interface matmul_if #(
    parameter int N  = 2,
    parameter int DW = 4,
    parameter int OW = matmul_pkg::ow_calc(DW, N)
) ();

    logic              in_valid;
    logic              in_ready;
    logic              acc_mode;
    logic [N*N*DW-1:0] a_flat;
    logic [N*N*DW-1:0] b_flat;
    logic [N*N*OW-1:0] c_flat;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_valid, acc_mode, a_flat, b_flat, out_ready,
        input  in_ready, c_flat, out_valid
    );

    modport slave (
        input  in_valid, acc_mode, a_flat, b_flat, out_ready,
        output in_ready, c_flat, out_valid
    );

endinterface

// File: rtl/matmul_mac.sv
// Combinational multiply-accumulate: sum = acc + a*b.
// The product is kept at full 2*DW width before widening.
module mac_unit #(
    parameter int DW = 4,
    parameter int OW = 9
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [OW-1:0] acc,
    output logic [OW-1:0] sum
);

    logic [2*DW-1:0] prod;

    assign prod = a * b;
    assign sum  = acc + OW'(prod);

endmodule

// File: rtl/matmul_seq.sv
// Sequential NxN matrix multiplier, C = A*B or C += A*B.
// One shared MAC walks an i/j/k loop, one product per cycle.
module matmul_seq #(
    parameter int N  = 2,
    parameter int DW = 4,
    parameter int OW = matmul_pkg::ow_calc(DW, N)
) (
    input  logic     clk,
    input  logic     rst,
    matmul_if.slave  bus
);

    import matmul_pkg::*;

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t            state;
    logic [N*N*DW-1:0] a_q;
    logic [N*N*DW-1:0] b_q;
    logic [N*N*OW-1:0] c_q;
    logic              mode_q;
    logic              ov_q;
    logic [OW-1:0]     acc;
    logic [IW-1:0]     i, j, k;

    int            aoff, boff, coff;
    logic [DW-1:0] a_el, b_el;
    logic [OW-1:0] sum, cold, wr;

    always_comb begin
        aoff = elem_off(int'(i), int'(k), N, DW);
        boff = elem_off(int'(k), int'(j), N, DW);
        coff = elem_off(int'(i), int'(j), N, OW);
        a_el = a_q[aoff +: DW];
        b_el = b_q[boff +: DW];
        // Element reads its own old value before being overwritten.
        cold = mode_q ? c_q[coff +: OW] : '0;
        wr   = sum + cold;
    end

    mac_unit #(
        .DW (DW),
        .OW (OW)
    ) u_mac (
        .a   (a_el),
        .b   (b_el),
        .acc (acc),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            mode_q <= 1'b0;
            ov_q   <= 1'b0;
            acc    <= '0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.a_flat;
                        b_q    <= bus.b_flat;
                        mode_q <= bus.acc_mode;
                        acc    <= '0;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (k == LAST) begin
                        c_q[coff +: OW] <= wr;
                        acc <= '0;
                        k   <= '0;
                        if (j == LAST) begin
                            j <= '0;
                            if (i == LAST) begin
                                i     <= '0;
                                ov_q  <= 1'b1;
                                state <= DONE;
                            end else begin
                                i <= i + IW'(1);
                            end
                        end else begin
                            j <= j + IW'(1);
                        end
                    end else begin
                        acc <= sum;
                        k   <= k + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ov_q  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = ov_q;
    assign bus.c_flat    = c_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed and randomized checks for matmul_seq at N=2 and N=3.
// Expected matrices are hand-computed or from a loop-nest model.
module tb_matmul_seq;

    logic clk = 1'b0;
    logic rst2, rst3;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    matmul_if #(.N(2), .DW(4), .OW(9))  u ();
    matmul_if #(.N(3), .DW(8), .OW(18)) v ();

    matmul_seq #(.N(2), .DW(4)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (u)
    );

    matmul_seq #(.N(3), .DW(8)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (v)
    );

    localparam logic [15:0] A1234 = {4'd4, 4'd3, 4'd2, 4'd1};
    localparam logic [15:0] B5678 = {4'd8, 4'd7, 4'd6, 4'd5};
    localparam logic [15:0] AID   = {4'd1, 4'd0, 4'd0, 4'd1};
    localparam logic [35:0] C_BASIC = {9'd50, 9'd43, 9'd22, 9'd19};

    task automatic run2(input logic [15:0] a, input logic [15:0] b,
                        input logic m, output logic [35:0] c,
                        output int lat, output bit busy_ok);
        u.a_flat   = a;
        u.b_flat   = b;
        u.acc_mode = m;
        u.in_valid = 1'b1;
        @(posedge clk); #1;
        u.in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!u.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (u.in_ready) busy_ok = 1'b0;
        end
        c = u.c_flat;
        u.out_ready = 1'b1;
        @(posedge clk); #1;
        u.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        u.in_valid = 1'b1; u.out_ready = 1'b0; u.acc_mode = 1'b0;
        u.a_flat = A1234; u.b_flat = B5678;
        v.in_valid = 1'b0; v.out_ready = 1'b0; v.acc_mode = 1'b0;
        v.a_flat = '0; v.b_flat = '0;
        rst2 = 1'b1; rst3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        u.in_valid = 1'b0;
        rst2 = 1'b0; rst3 = 1'b0;
        n_cmp++;
        if (u.c_flat !== 36'd0) begin
            n_bad++; $display("FAIL reset_c got %h want 0", u.c_flat);
        end
        n_cmp++;
        if (u.out_valid !== 1'b0 || u.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hs got ov=%b rdy=%b want ov=0 rdy=1",
                     u.out_valid, u.in_ready);
        end
        n_cmp++;
        if (v.c_flat !== '0 || v.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_n3 got rdy=%b want 1", v.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [35:0] c; int lat; bit ok;
        run2(A1234, B5678, 1'b0, c, lat, ok);
        n_cmp++;
        if (c !== C_BASIC) begin
            n_bad++; $display("FAIL basic_c got %h want %h", c, C_BASIC);
        end
        n_cmp++;
        if (lat !== 8) begin
            n_bad++; $display("FAIL basic_lat got %0d want 8", lat);
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++; $display("FAIL basic_busy got in_ready high want low");
        end
    endtask

    task automatic test_full_scale();
        logic [35:0] c; int lat; bit ok;
        run2(16'hFFFF, 16'hFFFF, 1'b0, c, lat, ok);
        n_cmp++;
        if (c !== {4{9'd450}}) begin
            n_bad++; $display("FAIL full_mul got %h want %h", c, {4{9'd450}});
        end
        run2(16'hFFFF, 16'hFFFF, 1'b1, c, lat, ok);
        n_cmp++;
        if (c !== {4{9'd388}}) begin
            n_bad++; $display("FAIL full_acc got %h want %h", c, {4{9'd388}});
        end
    endtask

    task automatic test_identity();
        logic [35:0] c; int lat; bit ok;
        logic [35:0] e1, e2;
        e1 = {9'd8, 9'd7, 9'd6, 9'd5};
        e2 = {9'd16, 9'd14, 9'd12, 9'd10};
        run2(AID, B5678, 1'b0, c, lat, ok);
        n_cmp++;
        if (c !== e1) begin
            n_bad++; $display("FAIL ident_mul got %h want %h", c, e1);
        end
        run2(AID, B5678, 1'b1, c, lat, ok);
        n_cmp++;
        if (c !== e2) begin
            n_bad++; $display("FAIL ident_acc got %h want %h", c, e2);
        end
        n_cmp++;
        if (lat !== 8) begin
            n_bad++; $display("FAIL ident_lat got %0d want 8", lat);
        end
    endtask

    task automatic test_backpressure();
        int t;
        u.a_flat = A1234; u.b_flat = B5678; u.acc_mode = 1'b0;
        u.in_valid = 1'b1;
        @(posedge clk); #1;
        u.in_valid = 1'b0;
        t = 0;
        while (!u.out_valid && t < 200) begin
            @(posedge clk); #1; t++;
        end
        n_cmp++;
        if (t !== 8) begin
            n_bad++; $display("FAIL bp_lat got %0d want 8", t);
        end
        for (int s = 0; s < 5; s++) begin
            u.in_valid = ~u.in_valid;
            u.a_flat = ~u.a_flat;
            @(posedge clk); #1;
            n_cmp++;
            if (u.c_flat !== C_BASIC || u.out_valid !== 1'b1 ||
                u.in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cyc %0d got c=%h ov=%b rdy=%b want c=%h ov=1 rdy=0",
                         s, u.c_flat, u.out_valid, u.in_ready, C_BASIC);
            end
        end
        u.in_valid = 1'b0;
        u.out_ready = 1'b1;
        @(posedge clk); #1;
        u.out_ready = 1'b0;
        n_cmp++;
        if (u.in_ready !== 1'b1 || u.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release got rdy=%b ov=%b want rdy=1 ov=0",
                     u.in_ready, u.out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (u.c_flat !== C_BASIC || u.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_idle got c=%h rdy=%b want c=%h rdy=1",
                     u.c_flat, u.in_ready, C_BASIC);
        end
    endtask

    task automatic test_reset_mid();
        logic [35:0] c; int lat; bit ok;
        u.a_flat = A1234; u.b_flat = B5678; u.acc_mode = 1'b1;
        u.in_valid = 1'b1;
        @(posedge clk); #1;
        u.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        n_cmp++;
        if (u.out_valid !== 1'b0 || u.c_flat !== 36'd0 ||
            u.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst got ov=%b c=%h rdy=%b want ov=0 c=0 rdy=1",
                     u.out_valid, u.c_flat, u.in_ready);
        end
        run2(A1234, B5678, 1'b0, c, lat, ok);
        n_cmp++;
        if (c !== C_BASIC || lat !== 8) begin
            n_bad++;
            $display("FAIL midrst_run got c=%h lat=%0d want c=%h lat=8",
                     c, lat, C_BASIC);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] c; int lat; bit ok;
        logic [35:0] e;
        e = {9'd100, 9'd86, 9'd44, 9'd38};
        run2(A1234, B5678, 1'b0, c, lat, ok);
        n_cmp++;
        if (u.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready got %b want 1", u.in_ready);
        end
        run2(A1234, B5678, 1'b1, c, lat, ok);
        n_cmp++;
        if (c !== e || lat !== 8 || ok !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_acc got c=%h lat=%0d want c=%h lat=8", c, lat, e);
        end
    endtask

    task automatic test_random_n3();
        longint prev [9];
        longint exp_c [9];
        longint s;
        int     ae [9];
        int     be [9];
        logic   m;
        int     lat, t;
        logic [161:0] got;
        for (int q = 0; q < 9; q++) prev[q] = 0;
        for (int it = 0; it < 100; it++) begin
            for (int q = 0; q < 9; q++) begin
                ae[q] = int'($urandom_range(0, 255));
                be[q] = int'($urandom_range(0, 255));
                v.a_flat[q*8 +: 8] = 8'(ae[q]);
                v.b_flat[q*8 +: 8] = 8'(be[q]);
            end
            if (it % 10 == 0) begin
                for (int q = 0; q < 9; q++) begin
                    ae[q] = 255; be[q] = 255;
                    v.a_flat[q*8 +: 8] = 8'd255;
                    v.b_flat[q*8 +: 8] = 8'd255;
                end
            end
            m = 1'($urandom_range(0, 1));
            for (int r = 0; r < 3; r++) begin
                for (int cc = 0; cc < 3; cc++) begin
                    s = 0;
                    for (int kk = 0; kk < 3; kk++)
                        s += longint'(ae[r*3+kk]) * longint'(be[kk*3+cc]);
                    if (m) s += prev[r*3+cc];
                    exp_c[r*3+cc] = s % 262144;
                end
            end
            v.acc_mode = m;
            v.in_valid = 1'b1;
            @(posedge clk); #1;
            v.in_valid = 1'b0;
            v.a_flat = '0;
            v.b_flat = '0;
            lat = 0;
            while (!v.out_valid && lat < 400) begin
                v.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                lat++;
            end
            n_cmp++;
            if (lat !== 27) begin
                n_bad++; $display("FAIL n3_lat it %0d got %0d want 27", it, lat);
            end
            got = v.c_flat;
            n_cmp++;
            for (int q = 0; q < 9; q++) begin
                if (longint'(got[q*18 +: 18]) !== exp_c[q]) begin
                    n_bad++;
                    $display("FAIL n3_c it %0d el %0d got %0d want %0d",
                             it, q, got[q*18 +: 18], exp_c[q]);
                    break;
                end
            end
            for (int q = 0; q < 9; q++) prev[q] = exp_c[q];
            t = 0;
            while (v.out_valid && t < 50) begin
                v.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                t++;
            end
            v.out_ready = 1'b0;
            if (t >= 50) begin
                n_cmp++; n_bad++;
                $display("FAIL n3_drain it %0d got stuck want release", it);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_identity();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random_n3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
